// File: rtl/adc_acq_sample_packer.sv
// adc_acq_sample_packer
//   Captures sample_count ADC samples after a start pulse, packs two samples
//   per 32-bit word ({hi16, lo16}, zero-extended), buffers the words in a
//   first-word-fall-through FIFO and emits them as a valid/ready stream whose
//   tlast marks every BURST_LEN-th word and the final word of the capture.
//
//   Optional build macro: ADC_ACQ_TEST_PATTERN_EN adds test_mode, which
//   replaces each accepted sample with a per-capture SAMPLE_W-bit counter.
//
// Ports
//   ACLK, ARESET        clock, asynchronous active-high reset
//   start, sample_count capture start pulse and sample count (latched on start)
//   adc_data, adc_valid ADC sample stream (no backpressure)
//   test_mode           test-pattern select (only with ADC_ACQ_TEST_PATTERN_EN)
//   m_tdata/m_tvalid/m_tready/m_tlast   packed word output stream
//   busy, done, overflow                status: active, drained pulse, sticky drop
module adc_acq_sample_packer #(
   parameter int SAMPLE_W   = 12,
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                start,
   input  logic [31:0]         sample_count,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
`ifdef ADC_ACQ_TEST_PATTERN_EN
   input  logic                test_mode,
`endif
   output logic [31:0]         m_tdata,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic                m_tlast,
   output logic                busy,
   output logic                done,
   output logic                overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;
   state_t r_state, w_next;

   logic [31:0]   r_samples_left, r_words_left;
   logic          r_phase;
   logic [15:0]   r_lo;
   logic          r_push;
   logic [31:0]   r_push_data;
   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [BW-1:0] r_beat;
   logic          r_overflow;

   logic          w_start_ok, w_accept, w_last_smp, w_pop, w_full, w_wr, w_drop, w_final;
   logic [15:0]   w_smp16;

   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_accept   = (r_state == S_CAPTURE) && adc_valid;
   assign w_last_smp = w_accept && (r_samples_left == 32'd1);
   assign w_pop      = m_tvalid && m_tready;
   // Full is judged on the pre-pop count: a same-cycle pop does not save the word.
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_wr       = r_push && !w_full;
   assign w_drop     = r_push && w_full;
   // words_left counts words not yet popped or dropped, including those still
   // upstream of the FIFO, so a value of 1 with a word at the head means the
   // head is the last word of the capture.
   assign w_final    = (r_words_left == 32'd1);

`ifdef ADC_ACQ_TEST_PATTERN_EN
   logic [SAMPLE_W-1:0] r_tp_cnt;
   assign w_smp16 = test_mode ? 16'(r_tp_cnt) : 16'(adc_data);
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)          r_tp_cnt <= '0;
      else if (w_start_ok) r_tp_cnt <= '0;
      else if (w_accept)   r_tp_cnt <= r_tp_cnt + SAMPLE_W'(1);
   end
`else
   assign w_smp16 = 16'(adc_data);
`endif

   // FSM state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM next state and status outputs
   always_comb begin
      w_next = r_state;
      busy   = (r_state != S_IDLE);
      done   = (r_state == S_DONE);
      case (r_state)
         S_IDLE:    if (start) w_next = (sample_count == 32'd0) ? S_DONE : S_CAPTURE;
         S_CAPTURE: if (w_last_smp) w_next = S_DRAIN;
         S_DRAIN:   if (r_words_left == 32'd0 && r_count == '0) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Sample packing: a completed word is staged in r_push_data and enters the
   // FIFO on the following edge.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_samples_left <= '0;
         r_phase        <= 1'b0;
         r_lo           <= '0;
         r_push         <= 1'b0;
         r_push_data    <= '0;
      end else begin
         r_push <= 1'b0;
         if (w_start_ok) begin
            r_samples_left <= sample_count;
            r_phase        <= 1'b0;
         end else if (w_accept) begin
            r_samples_left <= r_samples_left - 32'd1;
            if (!r_phase) begin
               r_lo    <= w_smp16;
               r_phase <= 1'b1;
               if (w_last_smp) begin
                  r_push      <= 1'b1;
                  r_push_data <= {16'h0000, w_smp16};
               end
            end else begin
               r_phase     <= 1'b0;
               r_push      <= 1'b1;
               r_push_data <= {w_smp16, r_lo};
            end
         end
      end
   end

   // Word accounting, burst framing and overflow flag
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_words_left <= '0;
         r_beat       <= '0;
         r_overflow   <= 1'b0;
      end else if (w_start_ok) begin
         r_words_left <= (sample_count >> 1) + {31'd0, sample_count[0]};
         r_beat       <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_words_left <= r_words_left - {31'd0, w_pop} - {31'd0, w_drop};
         if (w_drop) r_overflow <= 1'b1;
         if (w_pop)
            r_beat <= (w_final || r_beat == BW'(BURST_LEN-1)) ? '0 : r_beat + BW'(1);
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
      end
   end

   // FIFO storage; contents are unobservable until written, so no reset
   always_ff @(posedge ACLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
   end

   assign m_tvalid = (r_count != '0);
   assign m_tdata  = m_tvalid ? r_mem[r_rd_ptr] : 32'd0;
   assign m_tlast  = m_tvalid && (r_beat == BW'(BURST_LEN-1) || w_final);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_adc_acq_sample_packer.sv
module tb_adc_acq_sample_packer;
   localparam int SAMPLE_W   = 12;
   localparam int BURST_LEN  = 8;
   localparam int FIFO_DEPTH = 64;
   localparam int CYC_LIMIT  = 3000;

   logic                ACLK = 1'b0;
   logic                ARESET = 1'b1;
   logic                start = 1'b0;
   logic [31:0]         sample_count = '0;
   logic [SAMPLE_W-1:0] adc_data = '0;
   logic                adc_valid = 1'b0;
   logic                test_mode = 1'b0;
   logic [31:0]         m_tdata;
   logic                m_tvalid, m_tready = 1'b1, m_tlast, busy, done, overflow;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int vld_cnt = 0;
   int smp_q[$];
   logic [32:0] out_q[$];
   logic [32:0] exp_q[$];

   adc_acq_sample_packer #(.SAMPLE_W(SAMPLE_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .sample_count(sample_count),
      .adc_data(adc_data), .adc_valid(adc_valid),
`ifdef ADC_ACQ_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .busy(busy), .done(done), .overflow(overflow));

   always #5 ACLK = ~ACLK;

   // Output monitor: records handshaken beats and checks stall stability.
   logic        prev_stall = 1'b0;
   logic [32:0] prev_beat  = '0;
   always @(negedge ACLK) begin
      if (ARESET) begin
         prev_stall = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (m_tvalid) vld_cnt++;
         if (prev_stall && m_tvalid) begin
            checks++;
            if ({m_tlast, m_tdata} !== prev_beat) begin
               errors++;
               $display("FAIL stall_hold: got last=%0b data=%h, want last=%0b data=%h",
                        m_tlast, m_tdata, prev_beat[32], prev_beat[31:0]);
            end
         end
         if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
         prev_stall = m_tvalid && !m_tready;
         prev_beat  = {m_tlast, m_tdata};
      end
   end

   // Reference: words from the sample list, first 'cap' kept, tlast on every
   // BURST_LEN-th emitted word and on the final emitted word.
   function automatic void build_exp(input int n, input int cap);
      int w, kept;
      logic [15:0] lo, hi;
      w = (n + 1) / 2;
      kept = (w < cap) ? w : cap;
      exp_q.delete();
      for (int k = 0; k < kept; k++) begin
         lo = 16'(smp_q[2*k]);
         hi = (2*k+1 < n) ? 16'(smp_q[2*k+1]) : 16'h0;
         exp_q.push_back({((k+1) % BURST_LEN == 0) || (k+1 == kept), hi, lo});
      end
   endfunction

   function automatic void rand_samples(input int n);
      smp_q.delete();
      for (int i = 0; i < n; i++) smp_q.push_back(int'($urandom_range((1 << SAMPLE_W) - 1)));
   endfunction

   // Stimulus driver: one capture of n samples from smp_q.
   // rmode 0: ready always high, 1: random ready, 2: ready low until all samples sent.
   task automatic run_capture(input int n, input int vprob, input int rmode,
                              output int cyc, output int busy_low);
      int idx;
      bit v;
      idx = 0; cyc = 0; busy_low = 0;
      out_q.delete();
      @(posedge ACLK); #1;
      start = 1'b1; sample_count = n; adc_valid = 1'b1; adc_data = SAMPLE_W'($urandom);
      m_tready = (rmode == 0);
      @(posedge ACLK); #1;
      start = 1'b0;
      while (!done && cyc < CYC_LIMIT) begin
         if (!busy) busy_low++;
         v = (idx < n) && ($urandom_range(99) < vprob);
         adc_valid = (idx < n) ? v : 1'($urandom_range(1));
         adc_data  = v ? SAMPLE_W'(smp_q[idx]) : SAMPLE_W'($urandom);
         m_tready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(1)) : (idx >= n);
         if (v) idx++;
         cyc++;
         @(posedge ACLK); #1;
      end
      if (cyc >= CYC_LIMIT) begin
         checks++; errors++;
         $display("FAIL timeout: no done after %0d cycles, required within %0d", cyc, CYC_LIMIT);
      end
      adc_valid = 1'b0; m_tready = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tdata, busy, done, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%0b l=%0b d=%h b=%0b dn=%0b ov=%0b, want all 0",
                  m_tvalid, m_tlast, m_tdata, busy, done, overflow);
      end
      @(negedge ACLK); ARESET = 1'b0;
   endtask

   task automatic test_basic16();
      int cyc, bl, base;
      smp_q.delete();
      for (int i = 1; i <= 16; i++) smp_q.push_back(i);
      build_exp(16, FIFO_DEPTH);
      base = done_cnt;
      run_capture(16, 100, 0, cyc, bl);
      checks++;
      if (out_q.size() != 8) begin errors++; $display("FAIL basic16_count: got %0d, want 8", out_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL basic16_word%0d: got %h, want %h", i, out_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_cnt - base != 1) begin errors++; $display("FAIL basic16_done: got %0d pulses, want 1", done_cnt - base); end
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL basic16_ovf: got %0b, want 0", overflow); end
   endtask

   task automatic test_odd5();
      int cyc, bl;
      logic [32:0] want [3];
      want[0] = {1'b0, 32'h000B000A}; want[1] = {1'b0, 32'h000D000C}; want[2] = {1'b1, 32'h0000000E};
      smp_q = '{'hA, 'hB, 'hC, 'hD, 'hE};
      run_capture(5, 70, 1, cyc, bl);
      checks++;
      if (out_q.size() != 3) begin errors++; $display("FAIL odd5_count: got %0d, want 3", out_q.size()); end
      for (int i = 0; i < 3 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== want[i]) begin
            errors++;
            $display("FAIL odd5_word%0d: got %h, want %h", i, out_q[i], want[i]);
         end
      end
   endtask

   task automatic test_latency();
      int base, n;
      base = done_cnt;
      m_tready = 1'b0;
      @(posedge ACLK); #1;
      start = 1'b1; sample_count = 2;
      @(posedge ACLK); #1;
      start = 1'b0; adc_valid = 1'b1; adc_data = 12'h123;
      @(posedge ACLK); #1;
      adc_data = 12'h456;
      @(posedge ACLK); #1;
      adc_valid = 1'b0;
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL latency_early: got tvalid=%0b, want 0", m_tvalid); end
      repeat (2) @(posedge ACLK);
      #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tdata} !== {2'b11, 32'h04560123}) begin
         errors++;
         $display("FAIL latency_word: got v=%0b l=%0b d=%h, want v=1 l=1 d=04560123", m_tvalid, m_tlast, m_tdata);
      end
      m_tready = 1'b1;
      n = 0;
      while (done_cnt == base && n < 20) begin @(posedge ACLK); #1; n++; end
      checks++;
      if (done_cnt - base != 1) begin errors++; $display("FAIL latency_done: got %0d pulses, want 1", done_cnt - base); end
      repeat (2) @(posedge ACLK);
   endtask

   task automatic test_stall40();
      int cyc, bl;
      rand_samples(40);
      build_exp(40, FIFO_DEPTH);
      run_capture(40, 100, 2, cyc, bl);
      checks++;
      if (out_q.size() != 20) begin errors++; $display("FAIL stall40_count: got %0d, want 20", out_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL stall40_word%0d: got %h, want %h", i, out_q[i], exp_q[i]);
         end
      end
      checks++;
      if (bl != 0) begin errors++; $display("FAIL stall40_busy: got %0d idle cycles before done, want 0", bl); end
   endtask

   task automatic test_overflow200();
      int cyc, bl, base;
      rand_samples(200);
      build_exp(200, FIFO_DEPTH);
      base = done_cnt;
      run_capture(200, 100, 2, cyc, bl);
      checks++;
      if (out_q.size() != FIFO_DEPTH) begin errors++; $display("FAIL ovf_count: got %0d, want %0d", out_q.size(), FIFO_DEPTH); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL ovf_word%0d: got %h, want %h", i, out_q[i], exp_q[i]);
         end
      end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b, want 1", overflow); end
      checks++;
      if (done_cnt - base != 1) begin errors++; $display("FAIL ovf_done: got %0d pulses, want 1", done_cnt - base); end
   endtask

   task automatic test_zero();
      int cyc, bl, base, vbase;
      base = done_cnt; vbase = vld_cnt;
      smp_q.delete();
      run_capture(0, 100, 0, cyc, bl);
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf_clear: got %0b, want 0", overflow); end
      checks++;
      if (cyc > 2) begin errors++; $display("FAIL zero_latency: got %0d cycles, want <= 2", cyc); end
      checks++;
      if (vld_cnt != vbase) begin errors++; $display("FAIL zero_tvalid: got %0d valid cycles, want 0", vld_cnt - vbase); end
      checks++;
      if (done_cnt - base != 1) begin errors++; $display("FAIL zero_done: got %0d pulses, want 1", done_cnt - base); end
   endtask

   task automatic test_reset_mid();
      int cyc, bl;
      m_tready = 1'b0;
      @(posedge ACLK); #1;
      start = 1'b1; sample_count = 20;
      @(posedge ACLK); #1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         adc_valid = 1'b1; adc_data = SAMPLE_W'($urandom);
         @(posedge ACLK); #1;
      end
      @(posedge ACLK); #2;
      ARESET = 1'b1;
      #1;
      checks++;
      if ({m_tvalid, m_tlast, m_tdata, busy, done, overflow} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got v=%0b l=%0b d=%h b=%0b dn=%0b ov=%0b, want all 0",
                  m_tvalid, m_tlast, m_tdata, busy, done, overflow);
      end
      adc_valid = 1'b0; m_tready = 1'b1;
      @(negedge ACLK); ARESET = 1'b0;
      rand_samples(4);
      build_exp(4, FIFO_DEPTH);
      run_capture(4, 100, 0, cyc, bl);
      checks++;
      if (out_q.size() != 2) begin errors++; $display("FAIL midreset_count: got %0d, want 2", out_q.size()); end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midreset_word%0d: got %h, want %h", i, out_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random();
      int cyc, bl, n, vp;
      for (int it = 0; it < 6; it++) begin
         n  = $urandom_range(128, 1);
         vp = $urandom_range(100, 40);
         rand_samples(n);
         build_exp(n, FIFO_DEPTH);
         run_capture(n, vp, 1, cyc, bl);
         checks++;
         if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d, want %0d (n=%0d)", it, out_q.size(), exp_q.size(), n);
         end
         for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand%0d_word%0d: got %h, want %h", it, i, out_q[i], exp_q[i]);
            end
         end
         checks++;
         if (overflow !== 1'b0) begin errors++; $display("FAIL rand%0d_ovf: got %0b, want 0", it, overflow); end
      end
   endtask

`ifdef ADC_ACQ_TEST_PATTERN_EN
   task automatic test_pattern();
      int cyc, bl;
      logic [32:0] want [2];
      want[0] = {1'b0, 32'h00010000}; want[1] = {1'b1, 32'h00030002};
      test_mode = 1'b1;
      rand_samples(4);
      run_capture(4, 60, 0, cyc, bl);
      test_mode = 1'b0;
      checks++;
      if (out_q.size() != 2) begin errors++; $display("FAIL tpat_count: got %0d, want 2", out_q.size()); end
      for (int i = 0; i < 2 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== want[i]) begin
            errors++;
            $display("FAIL tpat_word%0d: got %h, want %h", i, out_q[i], want[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic16();
      test_odd5();
      test_latency();
      test_stall40();
      test_overflow200();
      test_zero();
      test_reset_mid();
      test_random();
`ifdef ADC_ACQ_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
